onehot_decode_tx: RTL and testbench

//   Receiving end of the priority-encoder index stream. Accepts an encoded index plus valid
//   (a 2-bit code + valid pair for the 4-line case) over a valid/ready handshake, and registers
//   the one-hot decode of that index. Presents the one-hot to a downstream consumer over a

---
 rtl/onehot_dec_pkg.sv | 17 +
 rtl/onehot_decode_tx_gap_counter.sv | 28 ++
 rtl/onehot_decode_tx.sv | 84 ++++++++
 tb/tb_onehot_decode_tx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/onehot_dec_pkg.sv
// onehot_dec_pkg: shared state type and helpers for the one-hot decode transmitter
package onehot_dec_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, GAP} dec_state_t;

   localparam int MAX_OUT_W = 32;

   function automatic logic [MAX_OUT_W-1:0] onehot_of(input logic [4:0] idx);
      return MAX_OUT_W'(1) << idx;
   endfunction

   // Gap counter width: enough to hold GAP_CYCLES, never narrower than one bit
   function automatic int gap_w(input int gap_cycles);
      return gap_cycles > 0 ? $clog2(gap_cycles + 1) : 1;
   endfunction

endpackage

// File: rtl/onehot_decode_tx_gap_counter.sv
// gap_counter: loadable down-counter timing the idle gap after each output handshake
module gap_counter
   import onehot_dec_pkg::*;
#(
   parameter int GAP_CYCLES = 2,
   localparam int W = gap_w(GAP_CYCLES)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   // Load on request, otherwise count down and rest at zero
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - W'(1);

   assign done = count == W'(1);

endmodule

// File: rtl/onehot_decode_tx.sv
// onehot_decode_tx: registers the one-hot decode of an accepted index and hands it downstream
module onehot_decode_tx
   import onehot_dec_pkg::*;
#(
   parameter int IN_W       = 2,
   parameter int GAP_CYCLES = 2,
   parameter int CNT_W      = 8,
   localparam int OUT_W     = 2 ** IN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  in_idx,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_onehot,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic [CNT_W-1:0] txn_cnt
);

   localparam int GW = gap_w(GAP_CYCLES);

   dec_state_t state, state_d;
   logic       load, done, accept, emit;

   // in_ready depends on state only; forced low while reset is held
   assign in_ready = rst_n && state == IDLE;
   assign accept   = in_valid && state == IDLE;
   assign emit     = out_valid && out_ready;
   assign busy     = state != IDLE;

   // State register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_d;

   // Next state; the gap counter is loaded on the output handshake
   always_comb begin
      state_d = state;
      load    = 1'b0;
      case (state)
         IDLE:    if (accept) state_d = DRIVE;
         DRIVE:   if (emit) begin
                     state_d = GAP_CYCLES == 0 ? IDLE : GAP;
                     load    = 1'b1;
                  end
         GAP:     if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   gap_counter #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (GW'(GAP_CYCLES)),
      .done     (done)
   );

   // Output registers: set on accept, cleared and counted on the output handshake
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_onehot <= '0;
         out_valid  <= 1'b0;
         txn_cnt    <= '0;
      end else if (accept) begin
         out_onehot <= OUT_W'(onehot_of(5'(in_idx)));
         out_valid  <= 1'b1;
      end else if (emit) begin
         out_onehot <= '0;
         out_valid  <= 1'b0;
         txn_cnt    <= txn_cnt + CNT_W'(1);
      end

   a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid ? $onehot(out_onehot) : out_onehot == '0);

   a_valid_drive: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid == (state == DRIVE));

endmodule

// File: tb/tb_onehot_decode_tx.sv
// tb_onehot_decode_tx: random and directed checks of two instances (gap 2 and gap 0) against a transaction model
module tb_onehot_decode_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] in_idx = '0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;

   logic [1:0] ir, ov, bz;
   logic [3:0] oh [2];
   logic [7:0] tc [2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   onehot_decode_tx #(.IN_W(2), .GAP_CYCLES(2), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_idx(in_idx), .in_valid(in_valid), .in_ready(ir[0]),
      .out_onehot(oh[0]), .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0]), .txn_cnt(tc[0])
   );

   onehot_decode_tx #(.IN_W(2), .GAP_CYCLES(0), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_idx(in_idx), .in_valid(in_valid), .in_ready(ir[1]),
      .out_onehot(oh[1]), .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1]), .txn_cnt(tc[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction model: an item is held or not, and in_ready returns once
   // at least GAP cycles have elapsed since the last output handshake.
   int         gapv  [2] = '{2, 0};
   logic       held  [2] = '{1'b0, 1'b0};
   logic [1:0] midx  [2] = '{2'd0, 2'd0};
   int         since [2] = '{1000, 1000};
   logic [7:0] cnt   [2] = '{8'd0, 8'd0};
   int         hs    [2] = '{0, 0};

   always @(posedge clk) cyc++;

   always @(posedge clk or negedge rst_n)
      for (int i = 0; i < 2; i++)
         if (!rst_n) begin
            held[i] = 1'b0; since[i] = 1000; cnt[i] = '0; hs[i] = 0;
         end else if (!held[i] && since[i] >= gapv[i] && in_valid) begin
            held[i] = 1'b1; midx[i] = in_idx;
            if (since[i] < 1000) since[i]++;
         end else if (held[i] && out_ready) begin
            held[i] = 1'b0; since[i] = 0; cnt[i]++; hs[i]++;
         end else if (since[i] < 1000)
            since[i]++;

   always @(negedge clk)
      for (int i = 0; i < 2; i++) begin
         chk(i ? "in_ready0" : "in_ready", 32'(ir[i]), 32'(rst_n && !held[i] && since[i] >= gapv[i]));
         chk(i ? "out_valid0" : "out_valid", 32'(ov[i]), 32'(held[i]));
         chk(i ? "onehot0" : "onehot", 32'(oh[i]), held[i] ? 32'(4'b0001 << midx[i]) : 32'd0);
         chk(i ? "busy0" : "busy", 32'(bz[i]), 32'(held[i] || since[i] < gapv[i]));
         chk(i ? "txn_cnt0" : "txn_cnt", 32'(tc[i]), 32'(cnt[i]));
      end

   task automatic wait_ready();
      for (int k = 0; k < 20 && !ir[0]; k++) @(negedge clk);
      if (!ir[0]) chk("ready_timeout", 32'(ir[0]), 32'd1);
   endtask

   int t [4];
   int n0, n1;

   initial begin
      // 1: reset mid-DRIVE
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(ir[0]), 32'd0);
      chk("rst_out_valid", 32'(ov[0]), 32'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      in_idx = 2'd1; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      chk("drive_onehot", 32'(oh[0]), 32'h2);
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(ov[0]), 32'd0);
      chk("arst_onehot", 32'(oh[0]), 32'd0);
      chk("arst_in_ready", 32'(ir[0]), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 32'(bz[0]), 32'd0);
      chk("post_rst_cnt", 32'(tc[0]), 32'd0);
      // 2: single transfer of idx 3 with gap
      out_ready = 1'b1; in_idx = 2'd3; in_valid = 1'b1;
      @(negedge clk);
      chk("idx3_onehot", 32'(oh[0]), 32'h8);
      chk("idx3_valid", 32'(ov[0]), 32'd1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("idx3_cnt", 32'(tc[0]), 32'd1);
      chk("gap1_ready", 32'(ir[0]), 32'd0);
      @(negedge clk);
      chk("gap2_ready", 32'(ir[0]), 32'd0);
      @(negedge clk);
      chk("gap_end_ready", 32'(ir[0]), 32'd1);
      // 3: sweep
      for (int i = 0; i < 4; i++) begin
         in_idx = 2'(i); in_valid = 1'b1;
         wait_ready();
         @(negedge clk);
         chk("sweep_onehot", 32'(oh[0]), 32'd1 << i);
         t[i] = cyc;
         if (i > 0) chk("sweep_spacing", 32'(t[i] - t[i-1]), 32'd4);
      end
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      // 4: backpressure
      out_ready = 1'b0; in_idx = 2'd2; in_valid = 1'b1;
      wait_ready();
      @(negedge clk);
      in_idx = 2'd0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("bp_onehot", 32'(oh[0]), 32'h4);
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b0;
      chk("bp_last_onehot", 32'(oh[0]), 32'h4);
      @(negedge clk);
      chk("bp_done_valid", 32'(ov[0]), 32'd0);
      // 5: throughput with in_valid held, both gap settings
      in_valid = 1'b1;
      repeat (6) @(negedge clk);
      n0 = 0; n1 = 0;
      repeat (20) begin
         @(negedge clk);
         n0 += 32'(ov[0]);
         n1 += 32'(ov[1]);
      end
      chk("rate_gap2", 32'(n0), 32'd5);
      chk("rate_gap0", 32'(n1), 32'd10);
      // 6: 256 transactions wrap the counter
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 3000 && hs[0] < 256; k++) @(negedge clk);
      chk("wrap_hs", 32'(hs[0]), 32'd256);
      chk("wrap_cnt", 32'(tc[0]), 32'd0);
      // random traffic with occasional reset
      repeat (800) begin
         @(negedge clk);
         in_idx = 2'($urandom_range(0, 3));
         in_valid = 1'($urandom_range(0, 1));
         out_ready = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
      end
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
